// File: rtl/iqft3_pipelined_if.sv
// Vector bus for the 3-qubit inverse QFT pipeline.
// Carries one 8-amplitude complex input vector with its valid bit and the
// transformed output vector with its valid bit. Amplitudes are signed S3.4.
//   master : producer/consumer side (drives in_valid, iXYZ_*, reads out_valid, fXYZ_*)
//   slave  : datapath side (reads the input vector, drives the output vector)
interface iqft3_pipelined_if;
  localparam int unsigned TOTAL_WIDTH = 8;

  logic                          in_valid;
  logic signed [TOTAL_WIDTH-1:0] i000_r, i000_i, i001_r, i001_i;
  logic signed [TOTAL_WIDTH-1:0] i010_r, i010_i, i011_r, i011_i;
  logic signed [TOTAL_WIDTH-1:0] i100_r, i100_i, i101_r, i101_i;
  logic signed [TOTAL_WIDTH-1:0] i110_r, i110_i, i111_r, i111_i;

  logic                          out_valid;
  logic signed [TOTAL_WIDTH-1:0] f000_r, f000_i, f001_r, f001_i;
  logic signed [TOTAL_WIDTH-1:0] f010_r, f010_i, f011_r, f011_i;
  logic signed [TOTAL_WIDTH-1:0] f100_r, f100_i, f101_r, f101_i;
  logic signed [TOTAL_WIDTH-1:0] f110_r, f110_i, f111_r, f111_i;

  modport master (
    output in_valid,
    output i000_r, i000_i, i001_r, i001_i, i010_r, i010_i, i011_r, i011_i,
    output i100_r, i100_i, i101_r, i101_i, i110_r, i110_i, i111_r, i111_i,
    input  out_valid,
    input  f000_r, f000_i, f001_r, f001_i, f010_r, f010_i, f011_r, f011_i,
    input  f100_r, f100_i, f101_r, f101_i, f110_r, f110_i, f111_r, f111_i
  );

  modport slave (
    input  in_valid,
    input  i000_r, i000_i, i001_r, i001_i, i010_r, i010_i, i011_r, i011_i,
    input  i100_r, i100_i, i101_r, i101_i, i110_r, i110_i, i111_r, i111_i,
    output out_valid,
    output f000_r, f000_i, f001_r, f001_i, f010_r, f010_i, f011_r, f011_i,
    output f100_r, f100_i, f101_r, f101_i, f110_r, f110_i, f111_r, f111_i
  );
endinterface

// File: rtl/iqft3_pipelined.sv
// Fully pipelined 3-qubit inverse QFT, 7 register stages, one vector per cycle.
// S0 register + bit-reversal swap, S1 H(q0), S2 CROT(-pi/2) q0->q1, S3 H(q1),
// S4 CROT(-pi/4) q0->q2, S5 CROT(-pi/2) q1->q2, S6 H(q2) driving the outputs.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears data and valid bits
//   bus : iqft3_pipelined_if.slave (in_valid, iXYZ_r/i in; out_valid, fXYZ_r/i out)
module iqft3_pipelined (
  input  logic                clk,
  input  logic                rst,
  iqft3_pipelined_if.slave    bus
);

  localparam int unsigned TOTAL_WIDTH = 8;
  localparam int unsigned FRAC_WIDTH  = 4;
  localparam int unsigned N_AMP       = 8;
  localparam int unsigned N_STG       = 7;
  localparam int unsigned PROD_WIDTH  = 17;

  typedef logic signed [TOTAL_WIDTH-1:0] amp_t;
  typedef logic signed [PROD_WIDTH-1:0]  prod_t;

  // 1/sqrt(2) ~ 11/16, and the two conjugate phase factors
  localparam amp_t H_COEF = 8'sd11;
  localparam amp_t R2_RE  = 8'sd0;
  localparam amp_t R2_IM  = -8'sd16;
  localparam amp_t R4_RE  = 8'sd11;
  localparam amp_t R4_IM  = -8'sd11;

  amp_t              in_r [N_AMP];
  amp_t              in_i [N_AMP];
  amp_t              re_q [N_STG][N_AMP];
  amp_t              im_q [N_STG][N_AMP];
  amp_t              re_d [N_STG][N_AMP];
  amp_t              im_d [N_STG][N_AMP];
  logic [N_STG-1:0]  vld_q;
  logic [N_STG-1:0]  vld_d;

  // Clamp a wide signed value into the amplitude range
  function automatic amp_t sat(input prod_t x);
    amp_t y;
    if (x > 17'sd127)       y = 8'sd127;
    else if (x < -17'sd128) y = -8'sd128;
    else                    y = amp_t'(x[TOTAL_WIDTH-1:0]);
    return y;
  endfunction

  // Hadamard butterfly leg: sub=0 gives (a+b)*11>>>4, sub=1 gives (a-b)*11>>>4
  function automatic amp_t h_leg(input amp_t a, input amp_t b, input logic sub);
    logic signed [TOTAL_WIDTH:0] s;
    prod_t p;
    s = sub ? (9'(a) - 9'(b)) : (9'(a) + 9'(b));
    p = 17'(s) * 17'(H_COEF);
    return sat(p >>> FRAC_WIDTH);
  endfunction

  function automatic amp_t cmul_re(input amp_t ar, input amp_t ai, input amp_t cr, input amp_t ci);
    prod_t p;
    p = 17'(ar) * 17'(cr) - 17'(ai) * 17'(ci);
    return sat(p >>> FRAC_WIDTH);
  endfunction

  function automatic amp_t cmul_im(input amp_t ar, input amp_t ai, input amp_t cr, input amp_t ci);
    prod_t p;
    p = 17'(ar) * 17'(ci) + 17'(ai) * 17'(cr);
    return sat(p >>> FRAC_WIDTH);
  endfunction

  // Unpack the named input amplitudes into an index-addressable array
  assign in_r[0] = bus.i000_r;  assign in_i[0] = bus.i000_i;
  assign in_r[1] = bus.i001_r;  assign in_i[1] = bus.i001_i;
  assign in_r[2] = bus.i010_r;  assign in_i[2] = bus.i010_i;
  assign in_r[3] = bus.i011_r;  assign in_i[3] = bus.i011_i;
  assign in_r[4] = bus.i100_r;  assign in_i[4] = bus.i100_i;
  assign in_r[5] = bus.i101_r;  assign in_i[5] = bus.i101_i;
  assign in_r[6] = bus.i110_r;  assign in_i[6] = bus.i110_i;
  assign in_r[7] = bus.i111_r;  assign in_i[7] = bus.i111_i;

  // Next-state for every stage: pass-through first, then gate overrides
  always_comb begin
    vld_d = {vld_q[N_STG-2:0], bus.in_valid};

    for (int n = 0; n < 8; n++) begin
      // S0 bit-reverses the index (q2 q1 q0 -> q0 q1 q2), swapping 1<->4 and 3<->6
      re_d[0][n] = in_r[{n[0], n[1], n[2]}];
      im_d[0][n] = in_i[{n[0], n[1], n[2]}];
      for (int s = 1; s < 7; s++) begin
        re_d[s][n] = re_q[s-1][n];
        im_d[s][n] = im_q[s-1][n];
      end
    end

    for (int k = 0; k < 4; k++) begin
      // S1: H on q0, pairs (2k, 2k+1)
      re_d[1][2*k]   = h_leg(re_q[0][2*k], re_q[0][2*k+1], 1'b0);
      re_d[1][2*k+1] = h_leg(re_q[0][2*k], re_q[0][2*k+1], 1'b1);
      im_d[1][2*k]   = h_leg(im_q[0][2*k], im_q[0][2*k+1], 1'b0);
      im_d[1][2*k+1] = h_leg(im_q[0][2*k], im_q[0][2*k+1], 1'b1);
      // S3: H on q1, pairs (0,2) (1,3) (4,6) (5,7)
      re_d[3][(k%2)+4*(k/2)]   = h_leg(re_q[2][(k%2)+4*(k/2)], re_q[2][(k%2)+4*(k/2)+2], 1'b0);
      re_d[3][(k%2)+4*(k/2)+2] = h_leg(re_q[2][(k%2)+4*(k/2)], re_q[2][(k%2)+4*(k/2)+2], 1'b1);
      im_d[3][(k%2)+4*(k/2)]   = h_leg(im_q[2][(k%2)+4*(k/2)], im_q[2][(k%2)+4*(k/2)+2], 1'b0);
      im_d[3][(k%2)+4*(k/2)+2] = h_leg(im_q[2][(k%2)+4*(k/2)], im_q[2][(k%2)+4*(k/2)+2], 1'b1);
      // S6: H on q2, pairs (k, k+4)
      re_d[6][k]   = h_leg(re_q[5][k], re_q[5][k+4], 1'b0);
      re_d[6][k+4] = h_leg(re_q[5][k], re_q[5][k+4], 1'b1);
      im_d[6][k]   = h_leg(im_q[5][k], im_q[5][k+4], 1'b0);
      im_d[6][k+4] = h_leg(im_q[5][k], im_q[5][k+4], 1'b1);
    end

    // S2: CROT(-pi/2) q0->q1 on indices 3, 7
    re_d[2][3] = cmul_re(re_q[1][3], im_q[1][3], R2_RE, R2_IM);
    im_d[2][3] = cmul_im(re_q[1][3], im_q[1][3], R2_RE, R2_IM);
    re_d[2][7] = cmul_re(re_q[1][7], im_q[1][7], R2_RE, R2_IM);
    im_d[2][7] = cmul_im(re_q[1][7], im_q[1][7], R2_RE, R2_IM);
    // S4: CROT(-pi/4) q0->q2 on indices 5, 7
    re_d[4][5] = cmul_re(re_q[3][5], im_q[3][5], R4_RE, R4_IM);
    im_d[4][5] = cmul_im(re_q[3][5], im_q[3][5], R4_RE, R4_IM);
    re_d[4][7] = cmul_re(re_q[3][7], im_q[3][7], R4_RE, R4_IM);
    im_d[4][7] = cmul_im(re_q[3][7], im_q[3][7], R4_RE, R4_IM);
    // S5: CROT(-pi/2) q1->q2 on indices 6, 7
    re_d[5][6] = cmul_re(re_q[4][6], im_q[4][6], R2_RE, R2_IM);
    im_d[5][6] = cmul_im(re_q[4][6], im_q[4][6], R2_RE, R2_IM);
    re_d[5][7] = cmul_re(re_q[4][7], im_q[4][7], R2_RE, R2_IM);
    im_d[5][7] = cmul_im(re_q[4][7], im_q[4][7], R2_RE, R2_IM);
  end

  // Stage registers and valid shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < 7; s++) begin
        for (int n = 0; n < 8; n++) begin
          re_q[s][n] <= '0;
          im_q[s][n] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < 7; s++) begin
        for (int n = 0; n < 8; n++) begin
          re_q[s][n] <= re_d[s][n];
          im_q[s][n] <= im_d[s][n];
        end
      end
    end
  end

  assign bus.out_valid = vld_q[N_STG-1];
  assign bus.f000_r = re_q[6][0];  assign bus.f000_i = im_q[6][0];
  assign bus.f001_r = re_q[6][1];  assign bus.f001_i = im_q[6][1];
  assign bus.f010_r = re_q[6][2];  assign bus.f010_i = im_q[6][2];
  assign bus.f011_r = re_q[6][3];  assign bus.f011_i = im_q[6][3];
  assign bus.f100_r = re_q[6][4];  assign bus.f100_i = im_q[6][4];
  assign bus.f101_r = re_q[6][5];  assign bus.f101_i = im_q[6][5];
  assign bus.f110_r = re_q[6][6];  assign bus.f110_i = im_q[6][6];
  assign bus.f111_r = re_q[6][7];  assign bus.f111_i = im_q[6][7];

endmodule

// File: tb/tb_iqft3_pipelined.sv
// Directed and streaming bench for the 3-qubit inverse QFT pipeline.
module tb_iqft3_pipelined;

  typedef int vec_t [8];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iqft3_pipelined_if bus ();

  iqft3_pipelined dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic signed [7:0] o_r [8];
  logic signed [7:0] o_i [8];
  assign o_r[0] = bus.f000_r;  assign o_i[0] = bus.f000_i;
  assign o_r[1] = bus.f001_r;  assign o_i[1] = bus.f001_i;
  assign o_r[2] = bus.f010_r;  assign o_i[2] = bus.f010_i;
  assign o_r[3] = bus.f011_r;  assign o_i[3] = bus.f011_i;
  assign o_r[4] = bus.f100_r;  assign o_i[4] = bus.f100_i;
  assign o_r[5] = bus.f101_r;  assign o_i[5] = bus.f101_i;
  assign o_r[6] = bus.f110_r;  assign o_i[6] = bus.f110_i;
  assign o_r[7] = bus.f111_r;  assign o_i[7] = bus.f111_i;

  vec_t zv = '{default: 0};

  task automatic drive(input logic v, input vec_t r, input vec_t i);
    bus.in_valid = v;
    bus.i000_r = 8'(r[0]);  bus.i000_i = 8'(i[0]);
    bus.i001_r = 8'(r[1]);  bus.i001_i = 8'(i[1]);
    bus.i010_r = 8'(r[2]);  bus.i010_i = 8'(i[2]);
    bus.i011_r = 8'(r[3]);  bus.i011_i = 8'(i[3]);
    bus.i100_r = 8'(r[4]);  bus.i100_i = 8'(i[4]);
    bus.i101_r = 8'(r[5]);  bus.i101_i = 8'(i[5]);
    bus.i110_r = 8'(r[6]);  bus.i110_i = 8'(i[6]);
    bus.i111_r = 8'(r[7]);  bus.i111_i = 8'(i[7]);
  endtask

  function automatic int sat(input int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // Reference IQFT written as a gate list on an integer state vector
  function automatic void model(input vec_t ir, input vec_t ii, output vec_t xr, output vec_t xi);
    vec_t r, i;
    int a, b, c, d, m, cr, ci;
    for (int n = 0; n < 8; n++) begin
      r[n] = ir[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)];
      i[n] = ii[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)];
    end
    for (int g = 0; g < 6; g++) begin
      if (g == 0 || g == 2 || g == 5) begin
        m = (g == 0) ? 1 : ((g == 2) ? 2 : 4);
        for (int n = 0; n < 8; n++) begin
          if ((n & m) == 0) begin
            a = r[n]; b = r[n | m]; c = i[n]; d = i[n | m];
            r[n]     = sat(((a + b) * 11) >>> 4);
            r[n | m] = sat(((a - b) * 11) >>> 4);
            i[n]     = sat(((c + d) * 11) >>> 4);
            i[n | m] = sat(((c - d) * 11) >>> 4);
          end
        end
      end else begin
        m  = (g == 1) ? 3 : ((g == 3) ? 5 : 6);
        cr = (g == 3) ? 11 : 0;
        ci = (g == 3) ? -11 : -16;
        for (int n = 0; n < 8; n++) begin
          if ((n & m) == m) begin
            a = r[n]; c = i[n];
            r[n] = sat((a * cr - c * ci) >>> 4);
            i[n] = sat((a * ci + c * cr) >>> 4);
          end
        end
      end
    end
    xr = r;
    xi = i;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, zv, zv);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", bus.out_valid);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (o_r[n] !== 8'sd0 || o_i[n] !== 8'sd0) begin
        failures++;
        $display("FAIL reset_data idx=%0d got=(%0d,%0d) want=(0,0)", n, o_r[n], o_i[n]);
      end
    end
    // in_valid held high across release: first valid output on the 7th edge
    drive(1'b1, zv, zv);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, zv, zv);
      checks++;
      if (bus.out_valid !== (k == 7)) begin
        failures++;
        $display("FAIL release_valid cycle=%0d got=%b want=%b", k, bus.out_valid, (k == 7));
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basis(input string name, input vec_t ir, input vec_t er, input vec_t ei);
    drive(1'b1, ir, zv);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, zv, zv);
      checks++;
      if (bus.out_valid !== (k == 7)) begin
        failures++;
        $display("FAIL %s_valid cycle=%0d got=%b want=%b", name, k, bus.out_valid, (k == 7));
      end
      if (k == 7) begin
        for (int n = 0; n < 8; n++) begin
          checks++;
          if (int'(o_r[n]) !== er[n] || int'(o_i[n]) !== ei[n]) begin
            failures++;
            $display("FAIL %s idx=%0d got=(%0d,%0d) want=(%0d,%0d)", name, n, o_r[n], o_i[n], er[n], ei[n]);
          end
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basis_000;
    vec_t ir = '{16, 0, 0, 0, 0, 0, 0, 0};
    vec_t er = '{4, 4, 4, 4, 4, 4, 4, 4};
    test_basis("basis000", ir, er, zv);
  endtask

  task automatic test_basis_001;
    vec_t ir = '{0, 16, 0, 0, 0, 0, 0, 0};
    vec_t er = '{4, 2, 0, -4, -5, -3, 0, 3};
    vec_t ei = '{0, -4, -5, -3, 0, 3, 4, 2};
    test_basis("basis001", ir, er, ei);
  endtask

  task automatic test_saturation;
    vec_t ir = '{-128, 0, 0, 0, -128, 0, 0, 0};
    vec_t er = '{-61, 0, -61, 0, -61, 0, -61, 0};
    vec_t mr, mi;
    model(ir, zv, mr, mi);
    test_basis("saturation", ir, er, zv);
    // the reference model applied to the same input must agree with the hand values
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (mr[n] !== er[n] || mi[n] !== 0) begin
        failures++;
        $display("FAIL sat_model idx=%0d got=(%0d,%0d) want=(%0d,0)", n, mr[n], mi[n], er[n]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    vec_t v = '{20, -7, 33, 0, 5, 9, -40, 12};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, v, v);
      @(negedge clk);
    end
    rst = 1'b1;
    drive(1'b1, v, v);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_valid cycle=%0d got=%b want=0", k, bus.out_valid);
      end
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (o_r[n] !== 8'sd0 || o_i[n] !== 8'sd0) begin
          failures++;
          $display("FAIL midrst_data idx=%0d got=(%0d,%0d) want=(0,0)", n, o_r[n], o_i[n]);
        end
      end
    end
    rst = 1'b0;
    drive(1'b0, v, v);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_ghost cycle=%0d got=%b want=0", k, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t sr [25];
    vec_t si [25];
    logic sv [25];
    vec_t mr, mi;
    for (int t = 0; t < 25; t++) begin
      sv[t] = (t < 20);
      for (int n = 0; n < 8; n++) begin
        sr[t][n] = int'($urandom_range(255)) - 128;
        si[t][n] = int'($urandom_range(255)) - 128;
      end
    end
    for (int t = 0; t < 33; t++) begin
      if (t >= 1) begin
        checks++;
        if (bus.out_valid !== ((t >= 7) ? sv[t-7] : 1'b0)) begin
          failures++;
          $display("FAIL stream_valid slot=%0d got=%b want=%b", t, bus.out_valid, (t >= 7) ? sv[t-7] : 1'b0);
        end
        if (t >= 7 && sv[t-7]) begin
          model(sr[t-7], si[t-7], mr, mi);
          for (int n = 0; n < 8; n++) begin
            checks++;
            if (int'(o_r[n]) !== mr[n] || int'(o_i[n]) !== mi[n]) begin
              failures++;
              $display("FAIL stream vec=%0d idx=%0d got=(%0d,%0d) want=(%0d,%0d)", t - 7, n, o_r[n], o_i[n], mr[n], mi[n]);
            end
          end
        end
      end
      if (t < 25) drive(sv[t], sr[t], si[t]);
      else        drive(1'b0, zv, zv);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, zv, zv);
    test_reset();
    test_basis_000();
    test_basis_001();
    test_saturation();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
